// File: rtl/pe_result_serializer.sv
// Per-PE result FIFOs drained round-robin onto a single valid/ready stream.
// Simultaneous PE results and downstream stalls are lossless up to FIFO_DEPTH
// per PE; dropped results raise a sticky overflow flag with the first dropper.
module pe_result_serializer #(
  parameter  int unsigned NUM_PE     = 8,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ID_W       = $clog2(NUM_PE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_PE-1:0]        pe_valid,
  input  logic [NUM_PE*DATA_W-1:0] pe_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_pe_id,
  output logic                     overflow,
  output logic [ID_W-1:0]          ovf_pe_id,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q    [NUM_PE][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_PE];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_PE];
  logic [CNT_W-1:0]  cnt_q    [NUM_PE];
  logic [CNT_W-1:0]  cnt_d    [NUM_PE];

  logic [NUM_PE-1:0] nonempty;
  logic [NUM_PE-1:0] push;
  logic [NUM_PE-1:0] pop;
  logic [NUM_PE-1:0] drop;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant;
  logic              grant_vld;
  logic              load;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [ID_W-1:0]   out_pe_id_q, out_pe_id_d;
  logic              overflow_q,  overflow_d;
  logic [ID_W-1:0]   ovf_pe_id_q, ovf_pe_id_d;

  // FIFO occupancy flags, taken from pre-edge state (no write-to-read bypass)
  always_comb begin
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
    end
  end

  // Round-robin search over non-empty FIFOs starting at rr_ptr, wrapping to 0
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_id;
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      idx    = (32'(rr_ptr_q) + k) % NUM_PE;
      idx_id = ID_W'(idx);
      if (!grant_vld && nonempty[idx_id]) begin
        grant_vld = 1'b1;
        grant     = idx_id;
      end
    end
  end

  // Push/pop/drop decisions, output register and overflow next-state
  always_comb begin
    load        = !out_valid_q || out_ready;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pe_id_d = out_pe_id_q;
    rr_ptr_d    = rr_ptr_q;
    overflow_d  = overflow_q;
    ovf_pe_id_d = ovf_pe_id_q;

    // A full FIFO still accepts a push when it is popped in the same cycle.
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      pop[i]   = load && grant_vld && (grant == ID_W'(i));
      push[i]  = pe_valid[i] && ((cnt_q[i] != CNT_W'(FIFO_DEPTH)) || pop[i]);
      drop[i]  = pe_valid[i] && (cnt_q[i] == CNT_W'(FIFO_DEPTH)) && !pop[i];
      cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end

    if (load) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[grant][rd_ptr_q[grant]];
        out_pe_id_d = grant;
        rr_ptr_d    = ID_W'((32'(grant) + 1) % NUM_PE);
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // Descending scan so the lowest dropping index wins on the first drop.
    if (!overflow_q && (drop != '0)) begin
      overflow_d = 1'b1;
      for (int unsigned i = NUM_PE; i > 0; i--) begin
        if (drop[i-1]) begin
          ovf_pe_id_d = ID_W'(i - 1);
        end
      end
    end
  end

  // FIFO storage writes; contents need no reset since counts gate reads
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (push[i]) begin
          mem_q[i][wr_ptr_q[i]] <= pe_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Pointers, counts, arbiter pointer and output/overflow registers
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pe_id_q <= '0;
      overflow_q  <= 1'b0;
      ovf_pe_id_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        cnt_q[i] <= cnt_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pe_id_q <= out_pe_id_d;
      overflow_q  <= overflow_d;
      ovf_pe_id_q <= ovf_pe_id_d;
    end
  end

  // busy: any buffered result or a result waiting in the output register
  always_comb begin
    busy = out_valid_q;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (nonempty[i]) busy = 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pe_id = out_pe_id_q;
  assign overflow  = overflow_q;
  assign ovf_pe_id = ovf_pe_id_q;

endmodule
